// File: rtl/sample_dma_pkg.sv
// sample_dma_pkg: shared constants and types for the sample DMA engine.
//   - per-channel register indices (low three bits of reg_addr)
//   - CTRL register bit positions
//   - transfer FSM state encoding
package sample_dma_pkg;

  localparam logic [2:0] RegCtrl  = 3'd0;
  localparam logic [2:0] RegBase  = 3'd1;
  localparam logic [2:0] RegSize  = 3'd2;
  localparam logic [2:0] RegWptr  = 3'd3;
  localparam logic [2:0] RegRptr  = 3'd4;
  localparam logic [2:0] RegLevel = 3'd5;
  localparam logic [2:0] RegDrops = 3'd6;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlOvfBit  = 1;
  localparam int unsigned CtrlFullBit = 2;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StCap,
    StWr
  } state_e;

endpackage

// File: rtl/sample_dma_ring.sv
// sample_dma_ring: one channel's ring-buffer bookkeeping.
// Holds enable/BASE/SIZE/WPTR/RPTR, derives full and LEVEL, and provides the
// combinational read data for this channel's register window.
// Optional SAMPLE_DMA_DROP_EN adds the overflow sticky bit and DROPS counter.
// Ports:
//   clk_48, irst          clock, asynchronous active-high reset
//   sel_i                 register access targets this channel
//   reg_idx_i             register index within the channel
//   reg_wdata_i, reg_we_i register write data and strobe
//   advance_i             SDRAM write for this channel completed
//   drop_i                a FIFO word was discarded (SAMPLE_DMA_DROP_EN only)
//   enable_o, full_o      channel state for the arbiter
//   base_o, wptr_o        next write address components
//   rdata_o               read data for reg_idx_i
module sample_dma_ring
  import sample_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk_48,
  input  logic              irst,
  input  logic              sel_i,
  input  logic [2:0]        reg_idx_i,
  input  logic [31:0]       reg_wdata_i,
  input  logic              reg_we_i,
  input  logic              advance_i,
`ifdef SAMPLE_DMA_DROP_EN
  input  logic              drop_i,
`endif
  output logic              enable_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] base_o,
  output logic [ADDR_W-1:0] wptr_o,
  output logic [31:0]       rdata_o
);

  logic              en_q, en_d;
  logic [ADDR_W-1:0] base_q, base_d, size_q, size_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   wptr_inc;
  logic [ADDR_W-1:0] wptr_next, level, wval;
  logic              wr;
  logic              unused_wdata;
`ifdef SAMPLE_DMA_DROP_EN
  logic              ovf_q, ovf_d;
  logic [15:0]       drops_q, drops_d;
`endif

  assign wval         = reg_wdata_i[ADDR_W-1:0];
  assign wr           = sel_i & reg_we_i;
  assign unused_wdata = ^reg_wdata_i;

  // >= rather than == keeps the pointer in range even if SIZE shrank while
  // a word was still in flight.
  assign wptr_inc  = {1'b0, wptr_q} + (ADDR_W + 1)'(1);
  assign wptr_next = (wptr_inc >= {1'b0, size_q}) ? '0 : wptr_inc[ADDR_W-1:0];
  assign full_o    = (wptr_next == rptr_q);
  assign level     = (wptr_q >= rptr_q) ? wptr_q - rptr_q : wptr_q + size_q - rptr_q;

  assign enable_o = en_q;
  assign base_o   = base_q;
  assign wptr_o   = wptr_q;

  always_comb begin
    en_d   = en_q;
    base_d = base_q;
    size_d = size_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
`ifdef SAMPLE_DMA_DROP_EN
    ovf_d   = ovf_q;
    drops_d = drops_q;
`endif
    if (advance_i) wptr_d = wptr_next;
    if (wr) begin
      case (reg_idx_i)
        RegCtrl: begin
          en_d = reg_wdata_i[CtrlEnBit];
          if (!en_q && reg_wdata_i[CtrlEnBit]) begin
            wptr_d = '0;
            rptr_d = '0;
          end
`ifdef SAMPLE_DMA_DROP_EN
          if (reg_wdata_i[CtrlOvfBit]) begin
            ovf_d   = 1'b0;
            drops_d = '0;
          end
`endif
        end
        RegBase: if (!en_q) base_d = wval;
        RegSize: if (!en_q) size_d = (wval < ADDR_W'(2)) ? ADDR_W'(2) : wval;
        RegRptr: if (reg_wdata_i < 32'(size_q)) rptr_d = wval;
        default: ;
      endcase
    end
`ifdef SAMPLE_DMA_DROP_EN
    if (drop_i) begin
      ovf_d = 1'b1;
      if (drops_d != 16'hffff) drops_d = drops_d + 16'd1;
    end
`endif
  end

  always_comb begin
    rdata_o = '0;
    case (reg_idx_i)
      RegCtrl: begin
        rdata_o[CtrlEnBit]   = en_q;
        rdata_o[CtrlFullBit] = full_o;
`ifdef SAMPLE_DMA_DROP_EN
        rdata_o[CtrlOvfBit]  = ovf_q;
`endif
      end
      RegBase:  rdata_o = 32'(base_q);
      RegSize:  rdata_o = 32'(size_q);
      RegWptr:  rdata_o = 32'(wptr_q);
      RegRptr:  rdata_o = 32'(rptr_q);
      RegLevel: rdata_o = 32'(level);
`ifdef SAMPLE_DMA_DROP_EN
      RegDrops: rdata_o = 32'(drops_q);
`endif
      default:  rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) begin
      en_q   <= 1'b0;
      base_q <= '0;
      size_q <= ADDR_W'(2);
      wptr_q <= '0;
      rptr_q <= '0;
`ifdef SAMPLE_DMA_DROP_EN
      ovf_q   <= 1'b0;
      drops_q <= '0;
`endif
    end else begin
      en_q   <= en_d;
      base_q <= base_d;
      size_q <= size_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`ifdef SAMPLE_DMA_DROP_EN
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
`endif
    end
  end

endmodule

// File: rtl/sample_dma.sv
// sample_dma: drains per-channel sample FIFOs into SDRAM ring buffers.
// A round-robin arbiter picks an eligible channel, the FSM pops one word,
// captures it and issues a single SDRAM write, then returns to idle.
// Optional macro SAMPLE_DMA_DROP_EN: words arriving for a full ring are popped
// and discarded (counted in DROPS) instead of stalling the FIFO.
// Ports:
//   clk_48, irst             clock, asynchronous active-high reset
//   fifo_empty/fifo_rd/fifo_data  per-channel FIFO read side
//   awaddr/wdata/wvalid/wready    SDRAM write channel
//   reg_addr/reg_wdata/reg_we/reg_re/reg_rdata  CPU register window
module sample_dma
  import sample_dma_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 24,
  localparam int unsigned RegAw   = $clog2(CHANNELS) + 3
) (
  input  logic                       clk_48,
  input  logic                       irst,
  input  logic [CHANNELS-1:0]        fifo_empty,
  output logic [CHANNELS-1:0]        fifo_rd,
  input  logic [CHANNELS*DATA_W-1:0] fifo_data,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [DATA_W-1:0]          wdata,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [RegAw-1:0]           reg_addr,
  input  logic [31:0]                reg_wdata,
  input  logic                       reg_we,
  input  logic                       reg_re,
  output logic [31:0]                reg_rdata
);

  localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e              state_q, state_d;
  logic [ChW-1:0]      cur_q, cur_d, rr_q, rr_d, ch_sel, off;
  logic [ChW:0]        cur_inc, pick;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wvalid_q, wvalid_d, found;
  logic [31:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] en, full, advance, elig;
  logic [2*CHANNELS-1:0] elig_rot;
  logic [ADDR_W-1:0]   base [CHANNELS];
  logic [ADDR_W-1:0]   wptr [CHANNELS];
  logic [DATA_W-1:0]   fifo_word [CHANNELS];
  logic [31:0]         ring_rdata [CHANNELS];
`ifdef SAMPLE_DMA_DROP_EN
  logic                drop_q, drop_d;
  logic [CHANNELS-1:0] drop;
`endif

  assign ch_sel = ChW'(reg_addr >> 3);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ring
    assign fifo_word[c] = fifo_data[c*DATA_W +: DATA_W];
`ifdef SAMPLE_DMA_DROP_EN
    // A full ring still competes so its FIFO can be drained and discarded.
    assign elig[c] = en[c] & ~fifo_empty[c];
`else
    assign elig[c] = en[c] & ~fifo_empty[c] & ~full[c];
`endif

    sample_dma_ring #(
      .ADDR_W(ADDR_W)
    ) u_ring (
      .clk_48     (clk_48),
      .irst       (irst),
      .sel_i      (ch_sel == ChW'(c)),
      .reg_idx_i  (reg_addr[2:0]),
      .reg_wdata_i(reg_wdata),
      .reg_we_i   (reg_we),
      .advance_i  (advance[c]),
`ifdef SAMPLE_DMA_DROP_EN
      .drop_i     (drop[c]),
`endif
      .enable_o   (en[c]),
      .full_o     (full[c]),
      .base_o     (base[c]),
      .wptr_o     (wptr[c]),
      .rdata_o    (ring_rdata[c])
    );
  end

  // Rotate so bit 0 is the rr channel; the lowest set bit wins.
  always_comb begin
    elig_rot = {elig, elig} >> rr_q;
    found    = 1'b0;
    off      = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        found = 1'b1;
        off   = ChW'(i);
      end
    end
    pick = {1'b0, rr_q} + {1'b0, off};
    if (pick >= (ChW + 1)'(CHANNELS)) pick = pick - (ChW + 1)'(CHANNELS);
    cur_inc = {1'b0, cur_q} + (ChW + 1)'(1);
    if (cur_inc >= (ChW + 1)'(CHANNELS)) cur_inc = '0;
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    fifo_rd  = '0;
    advance  = '0;
`ifdef SAMPLE_DMA_DROP_EN
    drop_d   = drop_q;
    drop     = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          cur_d   = pick[ChW-1:0];
          state_d = StPop;
`ifdef SAMPLE_DMA_DROP_EN
          drop_d  = full[pick[ChW-1:0]];
`endif
        end
      end
      StPop: begin
        fifo_rd[cur_q] = 1'b1;
        state_d        = StCap;
      end
      StCap: begin
        wdata_d  = fifo_word[cur_q];
        awaddr_d = base[cur_q] + wptr[cur_q];
        wvalid_d = 1'b1;
        state_d  = StWr;
`ifdef SAMPLE_DMA_DROP_EN
        if (drop_q) begin
          wdata_d     = wdata_q;
          awaddr_d    = awaddr_q;
          wvalid_d    = 1'b0;
          drop[cur_q] = 1'b1;
          rr_d        = cur_inc[ChW-1:0];
          state_d     = StIdle;
        end
`endif
      end
      StWr: begin
        if (wready) begin
          wvalid_d       = 1'b0;
          advance[cur_q] = 1'b1;
          rr_d           = cur_inc[ChW-1:0];
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Out-of-range channel numbers match no ring and read as zero.
  always_comb begin
    rdata_d = rdata_q;
    if (reg_re) begin
      rdata_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_sel == ChW'(c)) rdata_d = ring_rdata[c];
      end
    end
  end

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      rr_q     <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef SAMPLE_DMA_DROP_EN
      drop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rr_q     <= rr_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      rdata_q  <= rdata_d;
`ifdef SAMPLE_DMA_DROP_EN
      drop_q   <= drop_d;
`endif
    end
  end

  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_sample_dma.sv
// tb_sample_dma: directed bench for sample_dma with a ring/FIFO model.
// The bench owns the sample FIFOs (queues), tracks each ring's pointers from
// register writes and completed SDRAM writes, and checks every pop and write.
module tb_sample_dma;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int AW = 24;

  logic            clk_48 = 1'b0;
  logic            irst   = 1'b1;
  logic [CH-1:0]   fifo_empty = '1;
  logic [CH-1:0]   fifo_rd;
  logic [CH*DW-1:0] fifo_data = '0;
  logic [AW-1:0]   awaddr;
  logic [DW-1:0]   wdata;
  logic            wvalid;
  logic            wready = 1'b1;
  logic [3:0]      reg_addr = '0;
  logic [31:0]     reg_wdata = '0;
  logic            reg_we = 1'b0;
  logic            reg_re = 1'b0;
  logic [31:0]     reg_rdata;

  always #5 clk_48 = ~clk_48;

  sample_dma #(
    .CHANNELS(CH),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk_48    (clk_48),
    .irst      (irst),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .awaddr    (awaddr),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  int unsigned m_base [CH];
  int unsigned m_size [CH];
  int unsigned m_wptr [CH];
  int unsigned m_rptr [CH];
  int unsigned m_drops[CH];
  bit          m_en   [CH];
  bit          m_ovf  [CH];
  logic [DW-1:0] fq [CH][$];
  int            if_ch[$];
  logic [DW-1:0] if_data[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            log_ch[$];
  int unsigned   rst_exp [8] = '{0, 0, 2, 0, 0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_full(int c);
    int unsigned nxt;
    nxt = (m_wptr[c] + 1 >= m_size[c]) ? 0 : m_wptr[c] + 1;
    return nxt == m_rptr[c];
  endfunction

  function automatic int unsigned m_level(int c);
    return (m_wptr[c] >= m_rptr[c]) ? m_wptr[c] - m_rptr[c] : m_wptr[c] + m_size[c] - m_rptr[c];
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_base[c] = 0; m_size[c] = 2; m_wptr[c] = 0; m_rptr[c] = 0;
      m_drops[c] = 0; m_en[c] = 0; m_ovf[c] = 0;
    end
  endfunction

  // FIFO emulation and per-cycle output checks, away from the active edge.
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(negedge clk_48) begin : cmp
    logic [DW-1:0] w;
    int ch;
    if (irst) begin
      model_reset();
      if_ch.delete();
      if_data.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("wvalid_held", 32'(wvalid), 1);
        check("awaddr_held", 32'(awaddr), 32'(prev_addr));
        check("wdata_held", 32'(wdata), 32'(prev_data));
      end
      if (fifo_rd != '0) begin
        check("rd_onehot", 32'($onehot(fifo_rd)), 1);
        check("rd_while_wvalid", 32'(wvalid), 0);
        for (int c = 0; c < CH; c++) begin
          if (fifo_rd[c]) begin
            check("rd_enabled", 32'(m_en[c]), 1);
            check("rd_nonempty", 32'(fq[c].size() != 0), 1);
            if (fq[c].size() != 0) begin
              w = fq[c].pop_front();
              fifo_data[c*DW +: DW] = w;
`ifdef SAMPLE_DMA_DROP_EN
              if (m_full(c)) begin
                m_ovf[c] = 1;
                if (m_drops[c] < 65535) m_drops[c]++;
              end else begin
                if_ch.push_back(c);
                if_data.push_back(w);
              end
`else
              check("rd_ring_not_full", 32'(m_full(c)), 0);
              if_ch.push_back(c);
              if_data.push_back(w);
`endif
            end
          end
        end
      end
      if (wvalid && wready) begin
        check("inflight_words", if_ch.size(), 1);
        if (if_ch.size() != 0) begin
          ch = if_ch.pop_front();
          w  = if_data.pop_front();
          check("awaddr", 32'(awaddr), (m_base[ch] + m_wptr[ch]) % (1 << AW));
          check("wdata", 32'(wdata), 32'(w));
          log_addr.push_back(awaddr);
          log_data.push_back(wdata);
          log_ch.push_back(ch);
          m_wptr[ch] = (m_wptr[ch] + 1 >= m_size[ch]) ? 0 : m_wptr[ch] + 1;
        end
      end
      prev_stall = wvalid && !wready;
      prev_addr  = awaddr;
      prev_data  = wdata;
    end
    for (int c = 0; c < CH; c++) fifo_empty[c] = (fq[c].size() == 0);
  end

  task automatic reg_write(input int c, input int idx, input logic [31:0] v);
    @(posedge clk_48); #1;
    reg_addr = 4'(c * 8 + idx); reg_wdata = v; reg_we = 1'b1;
    @(posedge clk_48); #1;
    reg_we = 1'b0;
    case (idx)
      0: begin
        if (!m_en[c] && v[0]) begin m_wptr[c] = 0; m_rptr[c] = 0; end
        m_en[c] = v[0];
`ifdef SAMPLE_DMA_DROP_EN
        if (v[1]) begin m_ovf[c] = 0; m_drops[c] = 0; end
`endif
      end
      1: if (!m_en[c]) m_base[c] = v[AW-1:0];
      2: if (!m_en[c]) m_size[c] = (v[AW-1:0] < 2) ? 2 : v[AW-1:0];
      4: if (v < m_size[c]) m_rptr[c] = v;
      default: ;
    endcase
  endtask

  task automatic reg_read(input int c, input int idx, output logic [31:0] v);
    @(posedge clk_48); #1;
    reg_addr = 4'(c * 8 + idx); reg_re = 1'b1;
    @(posedge clk_48); #1;
    reg_re = 1'b0;
    v = reg_rdata;
  endtask

  task automatic check_reg(input string name, input int c, input int idx, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(c, idx, v);
    check(name, v, exp);
  endtask

  task automatic check_model_regs(input int c);
    check_reg("m_ctrl", c, 0, {29'd0, m_full(c), m_ovf[c], m_en[c]});
    check_reg("m_base", c, 1, m_base[c]);
    check_reg("m_size", c, 2, m_size[c]);
    check_reg("m_wptr", c, 3, m_wptr[c]);
    check_reg("m_rptr", c, 4, m_rptr[c]);
    check_reg("m_level", c, 5, m_level(c));
    check_reg("m_drops", c, 6, m_drops[c]);
    check_reg("m_unmapped", c, 7, 0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (log_addr.size() < n && k < budget) begin @(posedge clk_48); #1; k++; end
    check("writes_reached", log_addr.size(), n);
  endtask

  task automatic wait_wvalid(input int budget);
    int k = 0;
    while (!wvalid && k < budget) begin @(posedge clk_48); #1; k++; end
    check("wvalid_seen", 32'(wvalid), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_48); #1; end
  endtask

  initial begin
    int n0;
    model_reset();
    @(posedge clk_48); #1;
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    check("rst_awaddr", 32'(awaddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_rdata", reg_rdata, 0);
    idle(2);
    irst = 1'b0;

    // Reset register values
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < 8; i++) check_reg("rst_reg", c, i, rst_exp[i]);

    // Basic transfer
    reg_write(0, 1, 32'h1000);
    reg_write(0, 2, 8);
    reg_write(0, 0, 1);
    for (int i = 1; i <= 3; i++) fq[0].push_back(16'hA000 + 16'(i));
    wait_writes(3, 100);
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", 32'(log_addr[i]), 32'h1000 + i);
      check("t1_data", 32'(log_data[i]), 32'hA001 + i);
    end
    check_reg("t1_wptr", 0, 3, 3);
    check_reg("t1_level", 0, 5, 3);
    check_model_regs(0);

    // Full ring
    reg_write(0, 0, 0);
    reg_write(0, 1, 32'h2000);
    reg_write(0, 2, 4);
    reg_write(0, 0, 1);
    for (int i = 1; i <= 5; i++) fq[0].push_back(16'hB000 + 16'(i));
    wait_writes(6, 100);
    idle(30);
    check("t2_writes_after_full", log_addr.size(), 6);
`ifdef SAMPLE_DMA_DROP_EN
    check("t2_fifo_drained", fq[0].size(), 0);
    check_reg("t2_drops", 0, 6, 2);
    check_reg("t2_ctrl", 0, 0, 7);
    reg_write(0, 4, 2);
    idle(20);
    check("t2_no_more_writes", log_addr.size(), 6);
`else
    check("t2_fifo_left", fq[0].size(), 2);
    check_reg("t2_ctrl", 0, 0, 5);
    reg_write(0, 4, 2);
    wait_writes(8, 100);
    check("t2_addr6", 32'(log_addr[6]), 32'h2003);
    check("t2_data6", 32'(log_data[6]), 32'hB004);
    check("t2_addr7", 32'(log_addr[7]), 32'h2000);
    check("t2_data7", 32'(log_data[7]), 32'hB005);
    check_reg("t2_wptr", 0, 3, 1);
`endif
    check_model_regs(0);

    // Round-robin alternation
    reg_write(0, 0, 0);
    reg_write(0, 1, 32'h3000);
    reg_write(0, 2, 16);
    reg_write(1, 1, 32'h4000);
    reg_write(1, 2, 16);
    reg_write(0, 0, 1);
    reg_write(1, 0, 1);
    n0 = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      fq[0].push_back(16'hC000 + 16'(i));
      fq[1].push_back(16'hD000 + 16'(i));
    end
    wait_writes(n0 + 8, 200);
    for (int i = 1; i < 8; i++)
      if (n0 + i < log_ch.size())
        check("t3_alternate", 32'(log_ch[n0 + i] != log_ch[n0 + i - 1]), 1);
    check_model_regs(1);

    // wready stall with a disable while the word is in flight
    wready = 1'b0;
    fq[0].push_back(16'hE001);
    wait_wvalid(20);
    n0 = log_addr.size();
    reg_write(0, 0, 0);
    idle(8);
    check("t4_no_write_yet", log_addr.size(), n0);
    check("t4_wvalid_held", 32'(wvalid), 1);
    check("t4_awaddr", 32'(awaddr), 32'h3004);
    check("t4_wdata", 32'(wdata), 32'hE001);
    check("t4_fifo_rd_low", 32'(fifo_rd), 0);
    wready = 1'b1;
    idle(1);
    check("t4_wvalid_drop", 32'(wvalid), 0);
    check("t4_one_write", log_addr.size(), n0 + 1);
    check_reg("t4_wptr", 0, 3, 5);
    check_reg("t4_ctrl", 0, 0, 0);
    fq[0].push_back(16'hE002);
    idle(20);
    check("t4_disabled_no_write", log_addr.size(), n0 + 1);
    check("t4_disabled_fifo", fq[0].size(), 1);

    // Reset in the middle of a write
    fq[0].delete();
    wready = 1'b0;
    fq[1].push_back(16'hF001);
    wait_wvalid(20);
    n0 = log_addr.size();
    irst = 1'b1;
    #1;
    check("t5_wvalid", 32'(wvalid), 0);
    check("t5_fifo_rd", 32'(fifo_rd), 0);
    check("t5_awaddr", 32'(awaddr), 0);
    check("t5_rdata", reg_rdata, 0);
    @(posedge clk_48); #1;
    irst = 1'b0;
    wready = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < 8; i++) check_reg("t5_reg", c, i, rst_exp[i]);
    check("t5_no_write", log_addr.size(), n0);

    // Smallest ring, then more words than it can hold
    reg_write(0, 2, 1);
    reg_write(0, 1, 32'h5000);
    reg_write(0, 0, 1);
    check_reg("t6_size_clamp", 0, 2, 2);
    n0 = log_addr.size();
    fq[0].push_back(16'h5A01);
    wait_writes(n0 + 1, 50);
    check_reg("t6_ctrl_full", 0, 0, 5);
    for (int i = 2; i <= 4; i++) fq[0].push_back(16'h5A00 + 16'(i));
    idle(30);
    check("t6_writes", log_addr.size(), n0 + 1);
`ifdef SAMPLE_DMA_DROP_EN
    check("t6_fifo_drained", fq[0].size(), 0);
    check_reg("t6_ctrl_ovf", 0, 0, 7);
    check_reg("t6_drops", 0, 6, 3);
    reg_write(0, 0, 3);
    check_reg("t6_ctrl_clr", 0, 0, 5);
    check_reg("t6_drops_clr", 0, 6, 0);
`else
    check("t6_fifo_stalled", fq[0].size(), 3);
    check_reg("t6_drops", 0, 6, 0);
`endif
    check_model_regs(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_dma.md
Name: sample_dma

Overview:
- Multi-channel DMA engine that drains sampler clock-domain FIFOs (read side on clk_48) into per-channel ring buffers in SDRAM.
- Replaces CPU polling of sample FIFOs with autonomous writes on the sdram write channel (awaddr/wdata/wvalid/wready).
- CPU configures each ring and consumes it through a small register window on the io bus.

Parameters:
CHANNELS, 2, number of sample FIFOs/rings (1..4)
DATA_W, 16, FIFO and SDRAM word width
ADDR_W, 24, SDRAM word-address width

Ports:
clk_48  in  1  system clock
irst  in  1  reset
fifo_empty  in  CHANNELS  per-channel FIFO empty
fifo_rd  out  CHANNELS  per-channel FIFO pop; data valid the cycle after
fifo_data  in  CHANNELS*DATA_W  FIFO read data; channel c at [c*DATA_W +: DATA_W]
awaddr  out  ADDR_W  SDRAM write word address
wdata  out  DATA_W  SDRAM write data
wvalid  out  1  write request
wready  in  1  write accepted when wvalid&&wready
reg_addr  in  clog2(CHANNELS)+3  {channel, register index}
reg_wdata  in  32  register write data
reg_we  in  1  register write strobe, single cycle
reg_re  in  1  register read strobe
reg_rdata  out  32  read data, registered, valid the cycle after reg_re

Behaviour:
- Reset and clock: irst, asynchronous, active-high; clock clk_48.
- Reset values: fifo_rd=0, wvalid=0, awaddr=0, wdata=0, reg_rdata=0, all enables 0, all pointers 0, BASE=0, SIZE=2, rr pointer=0.
- Registers per channel:
  - 0 CTRL. W: bit0 enable, bit1 write-1-clear overflow. R: bit0 enable, bit1 overflow, bit2 full.
  - 1 BASE, ADDR_W bits.
  - 2 SIZE, ADDR_W bits.
  - 3 WPTR, read-only.
  - 4 RPTR, read/write.
  - 5 LEVEL, read-only.
  - Unmapped addresses read 0.
- BASE and SIZE writes are accepted only while enable=0. A SIZE write below 2 is clamped to 2.
- An enable 0->1 write clears WPTR and RPTR to 0.
- An RPTR write with value >= SIZE is ignored.
- Ring rules:
  - One-slot-empty. full = (WPTR+1, wrapped to 0 at SIZE) == RPTR.
  - LEVEL = WPTR>=RPTR ? WPTR-RPTR : WPTR+SIZE-RPTR.
- Channel eligible = enable && !fifo_empty && !full.
- FSM:
  - IDLE: round-robin search starting at rr; first eligible channel is latched as cur. -> POP.
  - POP: fifo_rd[cur]=1 for exactly one cycle. -> CAP.
  - CAP: wdata<=fifo_data[cur], awaddr<=BASE+WPTR (mod 2^ADDR_W), wvalid<=1. -> WR.
  - WR: wvalid, awaddr and wdata held until wready. On handshake: wvalid<=0, WPTR[cur] advances with wrap, rr<=cur+1 mod CHANNELS. -> IDLE.
- Throughput is at most one word per 4 cycles with wready tied high. Minimum latency from fifo_empty falling to wvalid is 3 cycles.
- Disable mid-transfer: the word in flight completes and WPTR advances. The channel is then ineligible.
- A same-cycle CPU RPTR write and WPTR advance both take effect. Full is re-evaluated the next cycle.
- Eligibility is sampled only in IDLE, so a channel whose FIFO empties during POP is never in flight.

Optional Feature:
- Macro SAMPLE_DMA_DROP_EN.
- Defined:
  - When a channel is enabled, full and !fifo_empty, the FIFO word is popped and discarded.
  - overflow sticky is set, and register 6 DROPS (16-bit, saturating) increments.
  - DROPS is cleared by the overflow write-1-clear.
  - Discard takes the POP/CAP path with no SDRAM write.
- Undefined: a full ring stalls the channel (backpressure to the FIFO). overflow and DROPS read 0.

Decomposition:
- Package sample_dma_pkg holds:
  - register index constants (CTRL, BASE, SIZE, WPTR, RPTR, LEVEL, DROPS);
  - CTRL bit positions;
  - FSM state enum IDLE/POP/CAP/WR.
- Sub-module sample_dma_ring, one instance per channel: config registers, pointers, full/LEVEL logic, and the register read mux for that channel.
- Top level holds the arbiter, FSM and SDRAM interface.

Test Plan:
- CH0 BASE=0x1000, SIZE=8, enable, FIFO pushes 0xA001..0xA003, wready=1 -> writes to 0x1000..0x1002 in order; WPTR=3; LEVEL=3.
- SIZE=4, RPTR=0, 5 words pushed -> 3 written, then full=1 and the 4th stays in the FIFO. Write RPTR=2 -> remaining words written at BASE+3 and BASE+0; WPTR=1.
- Both channels continuously non-empty -> SDRAM writes alternate ch0, ch1, ch0, ch1. Neither channel is granted twice in a row.
- wready held low 10 cycles -> wvalid, awaddr and wdata stable throughout; fifo_rd stays low; exactly one write completes on wready.
- Assert irst during WR -> wvalid=0 and fifo_rd=0 immediately; all registers read reset values.
- SAMPLE_DMA_DROP_EN defined, SIZE=2, ring full, 3 more words pushed -> FIFO drains; overflow=1; DROPS=3; no SDRAM writes. CTRL bit1 write clears both.
